// File: rtl/pipe_step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_step_ctrl_pkg
// Shared definitions for the debug run/step controller of the pipeline:
//   - state_e         : controller state encoding (also exported on o_state)
//   - CMD_*           : debug-unit command codes
//   - DRAIN_STEPS_DEF : default number of step cycles needed to retire the
//                       pipeline once a halt reaches the ID/EX register
//   - cmd_is_legal()  : true for the five defined command codes
// -----------------------------------------------------------------------------
package pipe_step_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4,
    ST_FLUSH  = 3'd5
  } state_e;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_RUN   = 3'b001;
  localparam logic [2:0] CMD_STEP  = 3'b010;
  localparam logic [2:0] CMD_FLUSH = 3'b011;
  localparam logic [2:0] CMD_PAUSE = 3'b100;

  localparam int DRAIN_STEPS_DEF = 3;

  // Codes above PAUSE are reserved.
  function automatic logic cmd_is_legal(input logic [2:0] cmd);
    return (cmd <= CMD_PAUSE);
  endfunction

endpackage

// File: rtl/pipe_step_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_step_ctrl_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   i_clk   : clock
//   i_rst   : synchronous active-high reset (clears count)
//   i_clr   : synchronous clear
//   i_inc   : count enable
//   o_count : current count
// -----------------------------------------------------------------------------
module pipe_step_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= {W{1'b0}};
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_step_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_step_ctrl
// Debug run/step controller. Gates the pipeline step enable from debug-unit
// commands, drains the pipeline after a halt instruction reaches ID/EX and
// provides a one-cycle synchronous pipeline flush.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_cmd_valid/i_cmd, o_cmd_ready : command handshake (consumed on valid&ready)
//   i_ex_halt       : halt flag at the ID/EX register output
//   o_step          : step enable to PC and pipeline registers
//   o_pipe_flush    : one-cycle clear of PC and pipeline registers
//   o_halted        : pipeline drained after a halt
//   o_busy          : stepping (RUN, STEP or DRAIN)
//   o_step_done     : pulse the cycle after a single STEP returns to IDLE
//   o_cmd_err       : pulse the cycle after an illegal/out-of-state command
//   o_state         : current state encoding
//   o_cycle_count   : saturating count of step cycles since reset/flush
// -----------------------------------------------------------------------------
module pipe_step_ctrl
  import pipe_step_ctrl_pkg::*;
#(
  parameter int DRAIN_STEPS = DRAIN_STEPS_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [2:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_ex_halt,
  output logic             o_step,
  output logic             o_pipe_flush,
  output logic             o_halted,
  output logic             o_busy,
  output logic             o_step_done,
  output logic             o_cmd_err,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam int               REM_W    = (DRAIN_STEPS < 2) ? 1 : $clog2(DRAIN_STEPS + 1);
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(DRAIN_STEPS);
  localparam logic [REM_W-1:0] REM_ZERO = {REM_W{1'b0}};

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_halt_pend;
  logic [REM_W-1:0] r_remaining;
  logic             r_step_done;
  logic             r_cmd_err;

  logic             w_step;
  logic             w_ready;
  logic             w_accept;
  logic             w_cmd_err;
  logic             w_detect;
  logic             w_pend_now;
  logic [REM_W-1:0] w_rem_base;
  logic [REM_W-1:0] w_rem_nxt;
  logic             w_drained;

  assign w_accept = i_cmd_valid & w_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Halt tracking: a new halt loads the drain budget, and the detection cycle
  // itself already counts as a drain step when the pipeline is stepping.
  always_comb begin
    w_detect   = i_ex_halt & ~r_halt_pend;
    w_pend_now = r_halt_pend | w_detect;
    if (w_detect) begin
      w_rem_base = REM_LOAD;
    end else begin
      w_rem_base = r_remaining;
    end
    if (w_pend_now && w_step && (w_rem_base != REM_ZERO)) begin
      w_rem_nxt = w_rem_base - REM_W'(1);
    end else begin
      w_rem_nxt = w_rem_base;
    end
    w_drained = w_pend_now & w_step & (w_rem_nxt == REM_ZERO);
  end

  // Next-state and command-error decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_err   = w_accept & ~cmd_is_legal(i_cmd);
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (i_cmd == CMD_RUN)) begin
          // A halt already known only needs its remaining drain steps.
          if (w_pend_now) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else if (w_accept && (i_cmd == CMD_STEP)) begin
          w_state_nxt = ST_STEP;
        end else if (w_accept && (i_cmd == CMD_FLUSH)) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_accept && (i_cmd != CMD_NOP) && (i_cmd != CMD_PAUSE)) begin
          w_cmd_err = 1'b1;
        end else begin
          w_cmd_err = w_cmd_err;
        end
        // Halt handling takes priority over a PAUSE in the same cycle.
        if (w_drained) begin
          w_state_nxt = ST_HALTED;
        end else if (w_detect) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_accept && (i_cmd == CMD_PAUSE)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STEP: begin
        if (w_drained) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_drained) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        if (w_accept && (i_cmd == CMD_FLUSH)) begin
          w_state_nxt = ST_FLUSH;
        end else if (w_accept && (i_cmd != CMD_NOP)) begin
          w_cmd_err   = 1'b1;
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode straight from the registered state.
  always_comb begin
    w_step       = 1'b0;
    w_ready      = 1'b0;
    o_halted     = 1'b0;
    o_pipe_flush = 1'b0;
    case (r_state)
      ST_IDLE:   w_ready      = 1'b1;
      ST_RUN:    begin w_step = 1'b1; w_ready = 1'b1; end
      ST_STEP:   w_step       = 1'b1;
      ST_DRAIN:  w_step       = 1'b1;
      ST_HALTED: begin o_halted = 1'b1; w_ready = 1'b1; end
      ST_FLUSH:  o_pipe_flush = 1'b1;
      default:   w_ready      = 1'b0;
    endcase
  end

  assign o_step      = w_step;
  assign o_busy      = w_step;
  assign o_cmd_ready = w_ready;
  assign o_state     = r_state;
  assign o_step_done = r_step_done;
  assign o_cmd_err   = r_cmd_err;

  // Halt-pending / remaining-steps registers, cleared by reset and by FLUSH.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state == ST_FLUSH)) begin
      r_halt_pend <= 1'b0;
      r_remaining <= REM_ZERO;
    end else begin
      r_halt_pend <= w_pend_now;
      r_remaining <= w_rem_nxt;
    end
  end

  // One-cycle status pulses; a STEP that completes the drain reports halted instead of done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step_done <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_step_done <= (r_state == ST_STEP) & ~w_drained;
      r_cmd_err   <= w_cmd_err;
    end
  end

  pipe_step_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (r_state == ST_FLUSH),
    .i_inc   (w_step),
    .o_count (o_cycle_count)
  );

endmodule
